// File: rtl/cam_i2c_arbiter.sv
// Two-requester round-robin arbiter and write sequencer for the camera I2C master.
// Latches the granted write, pulses send, and reports done/timeout to the owner.
module cam_i2c_arbiter #(
  parameter int TIMEOUT_CYCLES = 4000
) (
  input  logic        clk400,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [7:0]  slave0,
  input  logic [7:0]  slave1,
  input  logic [15:0] reg0,
  input  logic [15:0] reg1,
  input  logic [7:0]  data0,
  input  logic [7:0]  data1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic        i2c_send,
  output logic [7:0]  i2c_slave,
  output logic [15:0] i2c_reg,
  output logic [7:0]  i2c_data,
  input  logic        i2c_ready,
  output logic        busy,
  output logic        owner
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          ready_q;
  logic          last_q;
  logic          owner_q;
  logic          busy_q;
  logic          send_q;
  logic          ack0_q, ack1_q;
  logic          err0_q, err1_q;
  logic [7:0]    slave_q;
  logic [15:0]   reg_q;
  logic [7:0]    data_q;

  logic gnt_v, gnt, cmpl, tmo;

  assign cmpl = i2c_ready & ~ready_q;
  assign tmo  = (cnt_q == TMAX);

  // On a tie, the requester not served last wins.
  always_comb begin
    gnt_v = req0 | req1;
    gnt   = (req0 & req1) ? ~last_q : req1;
  end

  always_ff @(posedge clk400) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      busy_q  <= 1'b0;
      send_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      slave_q <= '0;
      reg_q   <= '0;
      data_q  <= '0;
    end else begin
      ready_q <= i2c_ready;
      send_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (gnt_v) begin
            slave_q <= gnt ? slave1 : slave0;
            reg_q   <= gnt ? reg1 : reg0;
            data_q  <= gnt ? data1 : data0;
            owner_q <= gnt;
            last_q  <= gnt;
            send_q  <= 1'b1;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Completion beats a coincident timeout.
          if (cmpl || tmo) begin
            ack0_q  <= ~owner_q;
            ack1_q  <= owner_q;
            err0_q  <= ~cmpl & ~owner_q;
            err1_q  <= ~cmpl & owner_q;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign err0      = err0_q;
  assign err1      = err1_q;
  assign i2c_send  = send_q;
  assign i2c_slave = slave_q;
  assign i2c_reg   = reg_q;
  assign i2c_data  = data_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_cam_i2c_arbiter.sv
// Bench for cam_i2c_arbiter: vector table of grants plus hand sequences
// for timeout, completion/timeout boundary and reset during a transfer.
module tb_cam_i2c_arbiter;

  localparam int TO = 50;

  logic        clk400 = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [7:0]  slave0 = '0, slave1 = '0;
  logic [7:0]  data0 = '0, data1 = '0;
  logic [15:0] reg0 = '0, reg1 = '0;
  logic        ack0, ack1, err0, err1;
  logic        i2c_send, busy, owner;
  logic [7:0]  i2c_slave, i2c_data;
  logic [15:0] i2c_reg;
  logic        i2c_ready = 1'b1;

  int checks = 0;
  int failures = 0;

  int m_lo = 2;
  int m_hi = 30;
  int m_t = 0;
  bit m_act = 1'b0;
  bit m_stuck = 1'b0;

  always #5 clk400 = ~clk400;

  cam_i2c_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk400(clk400), .reset(reset),
    .req0(req0), .req1(req1),
    .slave0(slave0), .slave1(slave1),
    .reg0(reg0), .reg1(reg1),
    .data0(data0), .data1(data1),
    .ack0(ack0), .ack1(ack1),
    .err0(err0), .err1(err1),
    .i2c_send(i2c_send),
    .i2c_slave(i2c_slave), .i2c_reg(i2c_reg), .i2c_data(i2c_data),
    .i2c_ready(i2c_ready),
    .busy(busy), .owner(owner)
  );

  // Master model: drop ready m_lo cycles after send, raise m_hi later.
  always @(posedge clk400) begin
    #2;
    if (reset) begin
      m_act = 1'b0;
      i2c_ready = 1'b1;
    end else begin
      if (i2c_send) begin
        m_act = 1'b1;
        m_t = 0;
      end else if (m_act) begin
        m_t++;
      end
      if (m_act && !m_stuck) begin
        if (m_t == m_lo) i2c_ready = 1'b0;
        if (m_t == m_lo + m_hi) begin
          i2c_ready = 1'b1;
          m_act = 1'b0;
        end
      end
    end
  end

  typedef struct {
    logic        r0;
    logic        r1;
    logic [15:0] g0;
    logic [15:0] g1;
    logic        eo;
    logic [7:0]  es;
    logic [15:0] er;
    logic [7:0]  ed;
  } vec_t;

  vec_t tbl[8];

  task automatic tick;
    @(posedge clk400);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    req0 = v.r0;
    req1 = v.r1;
    reg0 = v.g0;
    reg1 = v.g1;
    slave0 = 8'h10;
    data0 = 8'h01;
    slave1 = 8'h36;
    data1 = 8'ha5;
  endtask

  // Called in an IDLE cycle with requests set; returns in the ack cycle.
  task automatic do_txn(input string nm, input logic eo,
                        input logic [7:0] es, input logic [15:0] er,
                        input logic [7:0] ed, input logic ee,
                        input int elat);
    int k;
    int nsend;
    tick;
    k = 0;
    while (!i2c_send && k < 20) begin
      tick;
      k++;
    end
    chk({nm, "_sendlat"}, k, 0);
    chk({nm, "_owner"}, {31'd0, owner}, {31'd0, eo});
    chk({nm, "_fields"}, {i2c_slave, i2c_reg, i2c_data}, {es, er, ed});
    chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
    reg0 = 16'hdead;
    reg1 = 16'hbeef;
    slave0 = 8'hff;
    data1 = 8'hee;
    k = 0;
    nsend = 0;
    do begin
      tick;
      k++;
      if (i2c_send) nsend++;
    end while (!(ack0 | ack1) && k < 200);
    chk({nm, "_acklat"}, k, elat);
    chk({nm, "_ack"}, {30'd0, ack1, ack0}, eo ? 32'd2 : 32'd1);
    chk({nm, "_err"}, {30'd0, err1, err0},
        ee ? (eo ? 32'd2 : 32'd1) : 32'd0);
    chk({nm, "_hold"}, {i2c_slave, i2c_reg, i2c_data}, {es, er, ed});
    chk({nm, "_nosend"}, nsend, 0);
  endtask

  initial begin
    vec_t z;
    int na;
    z = '{1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 8'h0, 16'h0, 8'h0};
    tbl[0] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0, 8'h10, 16'h0100, 8'h01};
    tbl[1] = '{1'b0, 1'b1, 16'h0100, 16'h3000, 1'b1, 8'h36, 16'h3000, 8'ha5};
    tbl[2] = '{1'b1, 1'b1, 16'h0200, 16'h1000, 1'b0, 8'h10, 16'h0200, 8'h01};
    tbl[3] = '{1'b1, 1'b1, 16'h0201, 16'h1000, 1'b1, 8'h36, 16'h1000, 8'ha5};
    tbl[4] = '{1'b1, 1'b1, 16'h0201, 16'h1001, 1'b0, 8'h10, 16'h0201, 8'h01};
    tbl[5] = '{1'b1, 1'b1, 16'h0202, 16'h1001, 1'b1, 8'h36, 16'h1001, 8'ha5};
    tbl[6] = '{1'b1, 1'b1, 16'h0202, 16'h1002, 1'b0, 8'h10, 16'h0202, 8'h01};
    tbl[7] = '{1'b1, 1'b1, 16'h0203, 16'h1002, 1'b1, 8'h36, 16'h1002, 8'ha5};

    reset = 1'b1;
    tick;
    tick;
    chk("rst_ctl", {25'd0, ack0, ack1, err0, err1, i2c_send, busy, owner}, 0);
    chk("rst_fields", {i2c_slave, i2c_reg, i2c_data}, 0);
    reset = 1'b0;
    tick;
    chk("idle_noreq", {30'd0, i2c_send, busy}, 0);

    apply(tbl[0]);
    for (int i = 0; i < 8; i++) begin
      do_txn($sformatf("vec%0d", i), tbl[i].eo, tbl[i].es, tbl[i].er,
             tbl[i].ed, 1'b0, 33);
      apply(i < 7 ? tbl[i + 1] : z);
      tick;
      chk($sformatf("vec%0d_idle", i), {30'd0, busy, i2c_send}, 0);
    end

    m_stuck = 1'b1;
    req1 = 1'b1;
    slave1 = 8'h37;
    reg1 = 16'h4000;
    data1 = 8'h11;
    do_txn("tmo", 1'b1, 8'h37, 16'h4000, 8'h11, 1'b1, TO);
    req1 = 1'b0;
    m_stuck = 1'b0;
    req0 = 1'b1;
    slave0 = 8'h10;
    reg0 = 16'h0500;
    data0 = 8'h22;
    tick;
    chk("tmo_idle", {30'd0, busy, i2c_send}, 0);
    do_txn("after_tmo", 1'b0, 8'h10, 16'h0500, 8'h22, 1'b0, 33);

    m_lo = 0;
    m_hi = TO - 1;
    slave0 = 8'h10;
    reg0 = 16'h0600;
    tick;
    do_txn("bnd", 1'b0, 8'h10, 16'h0600, 8'h22, 1'b0, TO);
    m_hi = TO;
    slave0 = 8'h10;
    reg0 = 16'h0601;
    tick;
    do_txn("bnd_late", 1'b0, 8'h10, 16'h0601, 8'h22, 1'b1, TO);

    m_lo = 2;
    m_hi = 30;
    slave0 = 8'h10;
    reg0 = 16'h0700;
    tick;
    tick;
    chk("rw_send", {31'd0, i2c_send}, 32'd1);
    na = 0;
    for (int i = 0; i < 9; i++) begin
      tick;
      if (ack0 | ack1 | err0 | err1) na++;
    end
    tick;
    if (ack0 | ack1 | err0 | err1) na++;
    reset = 1'b1;
    req0 = 1'b1;
    req1 = 1'b1;
    slave0 = 8'h10;
    reg0 = 16'h0800;
    data0 = 8'h33;
    slave1 = 8'h36;
    reg1 = 16'h0900;
    data1 = 8'h44;
    tick;
    reset = 1'b0;
    chk("rw_noack", na, 0);
    chk("rw_ctl", {25'd0, ack0, ack1, err0, err1, i2c_send, busy, owner}, 0);
    chk("rw_fields", {i2c_slave, i2c_reg, i2c_data}, 0);
    do_txn("rw_tie0", 1'b0, 8'h10, 16'h0800, 8'h33, 1'b0, 33);
    req0 = 1'b0;
    reg1 = 16'h0900;
    data1 = 8'h44;
    tick;
    do_txn("rw_tie1", 1'b1, 8'h36, 16'h0900, 8'h44, 1'b0, 33);
    req1 = 1'b0;
    tick;
    tick;
    chk("end_idle", {30'd0, busy, i2c_send}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
